// File: rtl/ins_fetcher_pkg.sv
// Shared opcode, RVC encoding and state definitions for the instruction fetcher.
package ins_fetcher_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RISC_B = 7'b1100011;

    // Low two bits of an instruction; 2'b11 marks a full 32-bit encoding.
    localparam logic [1:0] RVC_Q1   = 2'b01;
    localparam logic [1:0] RVC_Q2   = 2'b10;
    localparam logic [1:0] RVC_NONE = 2'b11;

    localparam logic [2:0] C_F3_JAL  = 3'b001;
    localparam logic [2:0] C_F3_J    = 3'b101;
    localparam logic [2:0] C_F3_BEQZ = 3'b110;
    localparam logic [2:0] C_F3_BNEZ = 3'b111;
    localparam logic [2:0] C_F3_JR   = 3'b100;

    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RESP,
        S_HOLD,
        S_WAIT_JALR
    } fetch_state_e;

endpackage

// File: rtl/ins_fetcher_if.sv
// Bundle of icache, decoder, ROB and branch-training signals around the fetch stage.
interface ins_fetcher_if;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;

    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] predict_nxt_pc;
    logic        IFetcher_stall;
    logic        IFetcher_clear;
    logic [31:0] IFetcher_new_addr;

    logic        rob_clear;
    logic [31:0] rob_new_addr;

    logic        br_update_valid;
    logic [31:0] br_update_pc;
    logic        br_update_taken;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_resp_valid, icache_resp_data,
        output ins_ready, ins, pc, predict_nxt_pc,
        input  IFetcher_stall, IFetcher_clear, IFetcher_new_addr,
        input  rob_clear, rob_new_addr,
        input  br_update_valid, br_update_pc, br_update_taken
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_resp_valid, icache_resp_data,
        input  ins_ready, ins, pc, predict_nxt_pc,
        output IFetcher_stall, IFetcher_clear, IFetcher_new_addr,
        output rob_clear, rob_new_addr,
        output br_update_valid, br_update_pc, br_update_taken
    );
endinterface

// File: rtl/ins_fetcher_branch_predictor.sv
// Branch history table of 2-bit saturating counters; lookup reads the pre-update value.
module ins_fetcher_branch_predictor
    import ins_fetcher_pkg::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic [BHT_BITS-1:0] lookup_idx,
    output logic                lookup_taken,
    input  logic                update_valid,
    input  logic [BHT_BITS-1:0] update_idx,
    input  logic                update_taken
);
    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0] bht [ENTRIES];

    assign lookup_taken = bht[lookup_idx][1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (rdy_in && update_valid) begin
            if (update_taken) begin
                if (bht[update_idx] != 2'b11) begin
                    bht[update_idx] <= bht[update_idx] + 2'd1;
                end
            end else if (bht[update_idx] != 2'b00) begin
                bht[update_idx] <= bht[update_idx] - 2'd1;
            end
        end
    end
endmodule

// File: rtl/ins_fetcher.sv
// Fetch stage: one icache window per instruction, RVC length detection and
// next-PC prediction for jumps and BHT-guided branches.
module ins_fetcher
    import ins_fetcher_pkg::*;
#(
    parameter int          BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic           clk_in,
    input logic           rst_in,
    input logic           rdy_in,
    ins_fetcher_if.master bus
);
    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_addr;
    logic         req_valid;
    logic [31:0]  ins_r;
    logic [31:0]  pc_r;
    logic [31:0]  nxt_pc_r;
    logic         ins_ready_r;
    logic         discard;
    logic         hold_jalr;

    logic [31:0]  data;
    logic [31:0]  imm_j, imm_b, imm_cj, imm_cb;
    logic [31:0]  len, target, pred_nxt;
    logic         is_rvc, is_jal, is_cj, is_br, is_cb, is_jalr;
    logic         bht_taken, taken;
    logic         redirect, outstanding, accept;
    logic [31:0]  redirect_addr;
    logic         unused_bits;

    assign data   = bus.icache_resp_data;
    assign imm_j  = {{12{data[31]}}, data[19:12], data[20], data[30:21], 1'b0};
    assign imm_b  = {{20{data[31]}}, data[7], data[30:25], data[11:8], 1'b0};
    assign imm_cj = {{21{data[12]}}, data[8], data[10:9], data[6], data[7],
                     data[2], data[11], data[5:3], 1'b0};
    assign imm_cb = {{24{data[12]}}, data[6:5], data[2], data[11:10], data[4:3], 1'b0};

    always_comb begin
        is_rvc   = data[1:0] != RVC_NONE;
        len      = is_rvc ? 32'd2 : 32'd4;
        is_jal   = !is_rvc && data[6:0] == OP_JAL;
        is_br    = !is_rvc && data[6:0] == OP_RISC_B;
        is_cj    = data[1:0] == RVC_Q1 && (data[15:13] == C_F3_J || data[15:13] == C_F3_JAL);
        is_cb    = data[1:0] == RVC_Q1 && (data[15:13] == C_F3_BEQZ || data[15:13] == C_F3_BNEZ);
        // C.JR / C.JALR share funct3 100 with C.MV/C.ADD; rs2=0 and rd!=0 isolate them.
        is_jalr  = (!is_rvc && data[6:0] == OP_JALR) ||
                   (data[1:0] == RVC_Q2 && data[15:13] == C_F3_JR &&
                    data[6:2] == 5'd0 && data[11:7] != 5'd0);
        taken    = is_jal || is_cj || ((is_br || is_cb) && bht_taken);
        target   = fetch_pc + (is_jal ? imm_j : is_cj ? imm_cj : is_br ? imm_b : imm_cb);
        pred_nxt = taken ? target : fetch_pc + len;
    end

    assign redirect      = bus.rob_clear || bus.IFetcher_clear;
    assign redirect_addr = bus.rob_clear ? {bus.rob_new_addr[31:1], 1'b0}
                                         : {bus.IFetcher_new_addr[31:1], 1'b0};
    assign outstanding   = state == S_WAIT_RESP && !bus.icache_resp_valid;
    assign accept        = state == S_HOLD && ins_ready_r && !bus.IFetcher_stall;

    ins_fetcher_branch_predictor #(.BHT_BITS(BHT_BITS)) u_bp (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .lookup_idx  (fetch_pc[BHT_BITS:1]),
        .lookup_taken(bht_taken),
        .update_valid(bus.br_update_valid),
        .update_idx  (bus.br_update_pc[BHT_BITS:1]),
        .update_taken(bus.br_update_taken)
    );

    // The icache address only moves while no request is outstanding, so it
    // previews the next fetch PC one cycle before the request is raised.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            req_valid   <= 1'b0;
            req_addr    <= 32'h0;
            ins_r       <= 32'h0;
            pc_r        <= 32'h0;
            nxt_pc_r    <= 32'h0;
            ins_ready_r <= 1'b0;
            discard     <= 1'b0;
            hold_jalr   <= 1'b0;
        end else if (rdy_in) begin
            if (redirect) begin
                fetch_pc    <= redirect_addr;
                ins_ready_r <= 1'b0;
                if (outstanding) begin
                    discard <= 1'b1;
                end else begin
                    discard   <= 1'b0;
                    state     <= S_IDLE;
                    req_valid <= 1'b0;
                    req_addr  <= redirect_addr;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        req_valid <= 1'b1;
                        req_addr  <= fetch_pc;
                        state     <= S_WAIT_RESP;
                    end
                    S_WAIT_RESP: begin
                        if (bus.icache_resp_valid) begin
                            req_valid <= 1'b0;
                            if (discard) begin
                                discard  <= 1'b0;
                                req_addr <= fetch_pc;
                                state    <= S_IDLE;
                            end else begin
                                ins_r       <= data;
                                pc_r        <= {fetch_pc[31:1], taken};
                                nxt_pc_r    <= pred_nxt;
                                hold_jalr   <= is_jalr;
                                ins_ready_r <= 1'b1;
                                state       <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (accept) begin
                            ins_ready_r <= 1'b0;
                            if (hold_jalr) begin
                                state <= S_WAIT_JALR;
                            end else begin
                                fetch_pc <= nxt_pc_r;
                                req_addr <= nxt_pc_r;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_JALR: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_addr  = req_addr;
    assign bus.ins_ready        = ins_ready_r;
    assign bus.ins              = ins_r;
    assign bus.pc               = pc_r;
    assign bus.predict_nxt_pc   = nxt_pc_r;

    assign unused_bits = ^{bus.br_update_pc[31:BHT_BITS+1], bus.br_update_pc[0],
                           bus.rob_new_addr[0], bus.IFetcher_new_addr[0]};
endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher: sequential, RVC, branch prediction,
// stall, JALR redirect, ROB flush and reset scenarios.
module tb_ins_fetcher;
    logic clk;
    logic rst;
    logic rdy;
    int   total;
    int   bad;

    ins_fetcher_if bus();

    ins_fetcher #(.BHT_BITS(6), .RESET_PC(32'h0)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok, output logic [31:0] addr);
        ok   = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.icache_req_valid === 1'b1) begin
                ok   = 1'b1;
                addr = bus.icache_req_addr;
            end else begin
                tick();
            end
        end
    endtask

    task automatic send_resp(input logic [31:0] d);
        bus.icache_resp_data  = d;
        bus.icache_resp_valid = 1'b1;
        tick();
        bus.icache_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (bus.ins_ready !== 1'b0 || bus.icache_req_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got ready=%b req=%b want 0 0", bus.ins_ready, bus.icache_req_valid);
        end
        total++;
        if ({bus.ins, bus.pc, bus.predict_nxt_pc, bus.icache_req_addr} !== 128'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got ins=%h pc=%h nxt=%h addr=%h want all 0",
                     bus.ins, bus.pc, bus.predict_nxt_pc, bus.icache_req_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] a;
        wait_req(ok, a);
        total++;
        if (!ok || a !== 32'h0) begin
            bad++;
            $display("[TB] FAIL seq_req got ok=%0d addr=%h want addr=00000000", ok, a);
        end
        send_resp(32'h00100093);
        total++;
        if (bus.ins_ready !== 1'b1 || bus.ins !== 32'h00100093) begin
            bad++;
            $display("[TB] FAIL seq_ins got ready=%b ins=%h want 1 00100093", bus.ins_ready, bus.ins);
        end
        total++;
        if (bus.pc !== 32'h0 || bus.predict_nxt_pc !== 32'h4) begin
            bad++;
            $display("[TB] FAIL seq_pred got pc=%h nxt=%h want 0 4", bus.pc, bus.predict_nxt_pc);
        end
        tick();
        total++;
        if (bus.ins_ready !== 1'b0 || bus.icache_req_addr !== 32'h4) begin
            bad++;
            $display("[TB] FAIL seq_next got ready=%b addr=%h want 0 4", bus.ins_ready, bus.icache_req_addr);
        end
    endtask

    task automatic test_rvc();
        bit ok;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            wait_req(ok, a);
            total++;
            if (!ok || a !== 32'(4 + 4 * i)) begin
                bad++;
                $display("[TB] FAIL walk_req got ok=%0d addr=%h want %h", ok, a, 32'(4 + 4 * i));
            end
            send_resp(32'h00100093);
            tick();
        end
        wait_req(ok, a);
        total++;
        if (!ok || a !== 32'h10) begin
            bad++;
            $display("[TB] FAIL rvc_req got ok=%0d addr=%h want 00000010", ok, a);
        end
        send_resp(32'hABCD0505);
        total++;
        if (bus.ins_ready !== 1'b1 || bus.ins[15:0] !== 16'h0505 ||
            bus.pc !== 32'h10 || bus.predict_nxt_pc !== 32'h12) begin
            bad++;
            $display("[TB] FAIL rvc_pred got ready=%b ins=%h pc=%h nxt=%h want 1 0505 10 12",
                     bus.ins_ready, bus.ins, bus.pc, bus.predict_nxt_pc);
        end
        tick();
        total++;
        if (bus.icache_req_addr !== 32'h12) begin
            bad++;
            $display("[TB] FAIL rvc_next got addr=%h want 00000012", bus.icache_req_addr);
        end
    endtask

    task automatic test_branch();
        bit ok;
        logic [31:0] a;
        wait_req(ok, a);
        send_resp(32'h00E0006F);
        total++;
        if (!ok || a !== 32'h12 || bus.pc !== 32'h13 || bus.predict_nxt_pc !== 32'h20) begin
            bad++;
            $display("[TB] FAIL jal_fwd got addr=%h pc=%h nxt=%h want 12 13 20", a, bus.pc, bus.predict_nxt_pc);
        end
        tick();
        wait_req(ok, a);
        send_resp(32'h00000863);
        total++;
        if (!ok || a !== 32'h20 || bus.pc !== 32'h20 || bus.predict_nxt_pc !== 32'h24) begin
            bad++;
            $display("[TB] FAIL br_weak got addr=%h pc=%h nxt=%h want 20 20 24", a, bus.pc, bus.predict_nxt_pc);
        end
        tick();
        bus.br_update_valid = 1'b1;
        bus.br_update_pc    = 32'h20;
        bus.br_update_taken = 1'b1;
        tick();
        tick();
        bus.br_update_valid = 1'b0;
        wait_req(ok, a);
        send_resp(32'hFFDFF06F);
        total++;
        if (!ok || a !== 32'h24 || bus.pc !== 32'h25 || bus.predict_nxt_pc !== 32'h20) begin
            bad++;
            $display("[TB] FAIL jal_back got addr=%h pc=%h nxt=%h want 24 25 20", a, bus.pc, bus.predict_nxt_pc);
        end
        tick();
        wait_req(ok, a);
        send_resp(32'h00000863);
        total++;
        if (!ok || a !== 32'h20 || bus.pc !== 32'h21 || bus.predict_nxt_pc !== 32'h30) begin
            bad++;
            $display("[TB] FAIL br_trained got addr=%h pc=%h nxt=%h want 20 21 30", a, bus.pc, bus.predict_nxt_pc);
        end
        tick();
        wait_req(ok, a);
        send_resp(32'h0000E401);
        total++;
        if (!ok || a !== 32'h30 || bus.pc !== 32'h30 || bus.predict_nxt_pc !== 32'h32) begin
            bad++;
            $display("[TB] FAIL cbnez got addr=%h pc=%h nxt=%h want 30 30 32", a, bus.pc, bus.predict_nxt_pc);
        end
        tick();
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] a;
        wait_req(ok, a);
        bus.IFetcher_stall = 1'b1;
        send_resp(32'h0000A039);
        total++;
        if (!ok || a !== 32'h32 || bus.ins_ready !== 1'b1 ||
            bus.pc !== 32'h33 || bus.predict_nxt_pc !== 32'h40) begin
            bad++;
            $display("[TB] FAIL cj got addr=%h ready=%b pc=%h nxt=%h want 32 1 33 40",
                     a, bus.ins_ready, bus.pc, bus.predict_nxt_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.ins_ready !== 1'b1 || bus.ins !== 32'h0000A039 || bus.pc !== 32'h33 ||
                bus.predict_nxt_pc !== 32'h40 || bus.icache_req_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold cycle=%0d got ready=%b ins=%h pc=%h nxt=%h req=%b want 1 a039 33 40 0",
                         i, bus.ins_ready, bus.ins, bus.pc, bus.predict_nxt_pc, bus.icache_req_valid);
            end
        end
        bus.IFetcher_stall = 1'b0;
        tick();
        total++;
        if (bus.ins_ready !== 1'b0 || bus.icache_req_addr !== 32'h40) begin
            bad++;
            $display("[TB] FAIL stall_release got ready=%b addr=%h want 0 40", bus.ins_ready, bus.icache_req_addr);
        end
    endtask

    task automatic test_jalr();
        bit ok;
        logic [31:0] a;
        wait_req(ok, a);
        send_resp(32'h00008067);
        total++;
        if (!ok || a !== 32'h40 || bus.ins_ready !== 1'b1 || bus.predict_nxt_pc !== 32'h44) begin
            bad++;
            $display("[TB] FAIL jalr_present got addr=%h ready=%b nxt=%h want 40 1 44", a, bus.ins_ready, bus.predict_nxt_pc);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.icache_req_valid !== 1'b0 || bus.ins_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL jalr_wait cycle=%0d got req=%b ready=%b want 0 0", i, bus.icache_req_valid, bus.ins_ready);
            end
        end
        bus.IFetcher_clear    = 1'b1;
        bus.IFetcher_new_addr = 32'h400;
        tick();
        bus.IFetcher_clear = 1'b0;
        total++;
        if (bus.icache_req_addr !== 32'h400) begin
            bad++;
            $display("[TB] FAIL jalr_addr got addr=%h want 00000400", bus.icache_req_addr);
        end
        wait_req(ok, a);
        total++;
        if (!ok || a !== 32'h400) begin
            bad++;
            $display("[TB] FAIL jalr_req got ok=%0d addr=%h want 00000400", ok, a);
        end
    endtask

    task automatic test_flush();
        bit ok;
        logic [31:0] a;
        bus.rob_clear    = 1'b1;
        bus.rob_new_addr = 32'h80;
        tick();
        bus.rob_clear = 1'b0;
        total++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h400) begin
            bad++;
            $display("[TB] FAIL flush_outstanding got req=%b addr=%h want 1 400", bus.icache_req_valid, bus.icache_req_addr);
        end
        send_resp(32'h00100093);
        total++;
        if (bus.ins_ready !== 1'b0 || bus.icache_req_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_drop got ready=%b req=%b want 0 0", bus.ins_ready, bus.icache_req_valid);
        end
        wait_req(ok, a);
        total++;
        if (!ok || a !== 32'h80 || bus.ins_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_req got ok=%0d addr=%h ready=%b want 80 0", ok, a, bus.ins_ready);
        end
        bus.IFetcher_stall = 1'b1;
        send_resp(32'h00100093);
        total++;
        if (bus.ins_ready !== 1'b1 || bus.pc !== 32'h80 || bus.predict_nxt_pc !== 32'h84) begin
            bad++;
            $display("[TB] FAIL flush_fetch got ready=%b pc=%h nxt=%h want 1 80 84", bus.ins_ready, bus.pc, bus.predict_nxt_pc);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        logic [31:0] a;
        rst = 1'b1;
        tick();
        total++;
        if (bus.ins_ready !== 1'b0 || bus.icache_req_valid !== 1'b0 ||
            {bus.ins, bus.pc, bus.predict_nxt_pc, bus.icache_req_addr} !== 128'h0) begin
            bad++;
            $display("[TB] FAIL reset_hold got ready=%b req=%b ins=%h pc=%h nxt=%h addr=%h want all 0",
                     bus.ins_ready, bus.icache_req_valid, bus.ins, bus.pc, bus.predict_nxt_pc, bus.icache_req_addr);
        end
        rst = 1'b0;
        bus.IFetcher_stall = 1'b0;
        wait_req(ok, a);
        total++;
        if (!ok || a !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_restart got ok=%0d addr=%h want 00000000", ok, a);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rdy   = 1'b1;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_data  = 32'h0;
        bus.IFetcher_stall    = 1'b0;
        bus.IFetcher_clear    = 1'b0;
        bus.IFetcher_new_addr = 32'h0;
        bus.rob_clear         = 1'b0;
        bus.rob_new_addr      = 32'h0;
        bus.br_update_valid   = 1'b0;
        bus.br_update_pc      = 32'h0;
        bus.br_update_taken   = 1'b0;

        test_reset();
        test_sequential();
        test_rvc();
        test_branch();
        test_stall();
        test_jalr();
        test_flush();
        test_reset_mid_hold();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ins_fetcher.md
# ins_fetcher

Instruction fetch stage directly upstream of the decoder. It holds the architectural fetch PC, requests one 32-bit window per instruction from the instruction cache, and determines the instruction length (RVC 16-bit or 32-bit). It predicts the next PC for branches and JAL/C.J/C.JAL and presents one instruction at a time to the decoder. It obeys the decoder's stall and JALR redirect, and the ROB's mispredict flush.

## Interface
- `BHT_BITS`, default 6: log2 of branch-history-table entries (64 two-bit counters).
- `RESET_PC`, default 32'h0: fetch PC after reset.

Ports (name, direction, width, meaning):
- `clk_in` in 1: system clock; the single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: when low, all state frozen.
- `icache_req_valid` out 1: request a fetch window.
- `icache_req_addr` out 32: halfword-aligned address.
- `icache_resp_valid` in 1: one-cycle pulse carrying `icache_resp_data`.
- `icache_resp_data` in 32: bytes [addr, addr+3].
- `ins_ready` out 1: `ins`/`pc`/`predict_nxt_pc` valid.
- `ins` out 32: raw instruction; for RVC, upper 16 bits are don't-care.
- `pc` out 32: {fetch_pc[31:1], predicted_taken}.
- `predict_nxt_pc` out 32: predicted next fetch PC.
- `IFetcher_stall` in 1: decoder cannot accept; hold outputs.
- `IFetcher_clear` in 1: JALR redirect pulse.
- `IFetcher_new_addr` in 32: JALR target.
- `rob_clear` in 1: mispredict flush pulse.
- `rob_new_addr` in 32: correct PC.
- `br_update_valid` in 1: resolved-branch training pulse.
- `br_update_pc` in 32: PC of the branch being trained.
- `br_update_taken` in 1: resolved direction.

## Operation
- **States:**
  - IDLE: issue request.
  - WAIT_RESP: one request outstanding.
  - HOLD: instruction presented.
  - WAIT_JALR: a JALR has been presented; stop fetching.
- **IDLE → WAIT_RESP:** drive `icache_req_valid=1`, `icache_req_addr=fetch_pc`. The request stays asserted until the response arrives.
- **WAIT_RESP on response:**
  - Latch data.
  - Length = 2 if data[1:0]≠2'b11, else 4.
  - Decode the prediction.
  - Set `ins_ready=1`, go to HOLD.
- **Prediction rules:**
  - JAL (opcode 1101111), C.J/C.JAL (quadrant 01, funct3 101/001): taken; target = pc + sign-extended J-immediate.
  - B-type (1100011), C.BEQZ/C.BNEZ (quadrant 01, funct3 110/111): taken iff BHT[pc[BHT_BITS:1]][1]; target = pc + B-immediate.
  - Everything else: not taken.
  - `predict_nxt_pc` = taken ? target : pc+len. Arithmetic is modulo 2^32.
- **HOLD:** the decoder accepts in any rdy cycle with `ins_ready=1` and `IFetcher_stall=0`. On accept:
  - If the instruction is a JALR (1100111, or quadrant 10 funct3 100 with rs2=0 and rd≠0): go to WAIT_JALR, `ins_ready=0`.
  - Otherwise: fetch_pc ← predict_nxt_pc, `ins_ready=0`, go to IDLE.
- **WAIT_JALR:** on `IFetcher_clear`, fetch_pc ← `IFetcher_new_addr`, go to IDLE.
- **Priority:** `rob_clear` > `IFetcher_clear` > accept.
  - `rob_clear` in any state: fetch_pc ← `rob_new_addr`, `ins_ready=0`.
  - If a request is outstanding, set `discard`, stay in WAIT_RESP, drop the next response, then go to IDLE.
  - `IFetcher_clear` is honoured in any state with the same discard rule.
- **BHT:**
  - Entries are 2-bit saturating counters, reset to 2'b01.
  - On `br_update_valid`: counter at index br_update_pc[BHT_BITS:1] increments if taken, decrements otherwise; saturates at 00/11.
  - An update and a lookup in the same cycle: the lookup sees the old value.
- **Reset:**
  - `rst_in` at any time, including mid-request: state IDLE, fetch_pc=`RESET_PC`, discard=0.
  - Outputs `ins_ready`, `icache_req_valid`, `ins`, `pc`, `predict_nxt_pc`, `icache_req_addr` all 0.
  - BHT = 01.
  - Because `icache_req_valid` is 0 in reset, no response is outstanding after reset.
- While `rdy_in=0`, nothing changes, including the BHT.

## Timing
- All outputs are registered.
- The request is issued the cycle after entering IDLE.
- `ins_ready` rises the cycle after `icache_resp_valid`.
- After an accept, the next request address appears the following cycle. Minimum issue interval is 3 cycles plus icache latency.
- A flush/clear in cycle t puts the new address on `icache_req_addr` in cycle t+1, or 1 cycle after the discarded response arrives.
- Outputs remain stable throughout HOLD while `IFetcher_stall=1`.

## Structure
- Shared `const.v`:
  - opcode localparams (JAL, JALR, RISC_B);
  - RVC quadrant/funct3 codes;
  - state encodings.
- Sub-module `branch_predictor`:
  - BHT array;
  - combinational lookup port `(pc → taken)`;
  - update port.
- Immediate extraction for J/B/CJ/CB stays in `ins_fetcher`.

## Test plan
- **Sequential fetch:** reset, RESET_PC=0, icache returns 32'h00100093 (addi) at 0 → `ins_ready`, pc=0, predict_nxt_pc=4; after accept, next request addr=4.
- **RVC:** data 32'hxxxx0505 (c.addi) at 0x10 → predict_nxt_pc=0x12; next request addr 0x12.
- **Branch and training:**
  - Branch at 0x20 with BHT=01 → pc[0]=0, predict 0x24.
  - After two `br_update_taken=1` pulses at 0x20 → pc[0]=1, predict = branch target.
- **Stall and JALR:**
  - `IFetcher_stall=1` for 5 cycles → outputs unchanged, no new request.
  - A JALR accept → no request until `IFetcher_clear` with addr 0x400; then request 0x400 the next cycle.
- **Flush:** `rob_clear` (addr 0x80) while in WAIT_RESP → the following response is dropped (`ins_ready` stays 0); the next request is 0x80. Also assert reset mid-HOLD → all outputs 0 the next cycle.
